// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single RAM port between the instruction cache (read-only) and the
// data cache (read/write). The data cache wins by default; a streak counter
// forces the instruction cache in after DSTREAK_MAX back-to-back data grants
// while an instruction request is waiting.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   iREN, iaddr         icache read request and address
//   iwait, iload        icache handshake (low one cycle on completion) and data
//   dREN, dWEN          dcache read / write request (write wins)
//   daddr, dstore       dcache address and write data
//   dwait, dload        dcache handshake (low one cycle on completion) and data
//   ramREN, ramWEN      RAM read / write enables (never both high)
//   ramaddr, ramstore   RAM address and write data
//   ramload, ramstate   RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   gnt_i, gnt_d        current grant holder, for debug and coverage
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              gnt_i,
  output logic              gnt_d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] STREAK_MAX = 4'(DSTREAK_MAX);

  state_t     state_q, state_d;
  logic [3:0] streak_q, streak_d;

  logic dreq, ireq, access;

  assign dreq   = dREN | dWEN;
  assign ireq   = iREN;
  assign access = (ramstate == RAM_ACCESS);

  assign gnt_i = (state_q == IGNT);
  assign gnt_d = (state_q == DGNT);

  // The RAM side follows the grant combinationally so that address changes
  // reach the RAM in the same cycle. Completion pulses are suppressed while
  // RST is high: the access is being torn down at this edge and the
  // requester must not see it as finished.
  always_comb begin
    // NOTE: every output and next-state signal gets a default before the case
    // statement, so no path through it can leave a signal unassigned and
    // infer a latch.
    state_d  = state_q;
    streak_d = streak_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        // Data priority, except when the instruction side has been passed
        // over DSTREAK_MAX times in a row.
        if (dreq && ireq && streak_q == STREAK_MAX) state_d = IGNT;
        else if (dreq)                              state_d = DGNT;
        else if (ireq)                              state_d = IGNT;
      end

      DGNT: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end

        if (!dreq) begin
          state_d = IDLE;                    // aborted, streak untouched
        end else if (access) begin
          state_d = IDLE;
          if (!RST) begin
            dwait = 1'b0;
            dload = dWEN ? '0 : ramload;
          end
          if (iREN) streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
          else      streak_d = 4'd0;
        end
      end

      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;

        if (!iREN) begin
          state_d = IDLE;
        end else if (access) begin
          state_d  = IDLE;
          streak_d = 4'd0;
          if (!RST) begin
            iwait = 1'b0;
            iload = ramload;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

endmodule
